// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the P7 PC register/hazard/CP0 side and the next-PC sequencer.
// master drives the requests and current PC; slave returns the PC load controls.
interface pc_sequencer_if;
  localparam int unsigned ADDR_W = 32;

  logic [ADDR_W-1:0] PCOut;
  logic              Stall;
  logic              BrValid;
  logic [ADDR_W-1:0] BrTarget;
  logic              ExcReq;
  logic              EretReq;
  logic [ADDR_W-1:0] EPC;
  logic              PCUpdate;
  logic [ADDR_W-1:0] PCIn;
  logic              Flush;
  logic              PendValid;

  modport master (
    output PCOut, Stall, BrValid, BrTarget, ExcReq, EretReq, EPC,
    input  PCUpdate, PCIn, Flush, PendValid
  );

  modport slave (
    input  PCOut, Stall, BrValid, BrTarget, ExcReq, EretReq, EPC,
    output PCUpdate, PCIn, Flush, PendValid
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC scheduler for the P7 PC register: arbitrates exception, ERET, redirect,
// stall and sequential advance; buffers a redirect that lands during a stall.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;

  logic              pc_update;
  logic [ADDR_W-1:0] pc_in;
  logic              flush;
  logic              pend_valid;
  logic [ADDR_W-1:0] pc_plus4;
  logic [1:0]        epc_lo_unused;

  assign pc_plus4      = bus.PCOut + ADDR_W'(4);
  assign epc_lo_unused = bus.EPC[1:0];

  // Next-state, pending target and same-cycle PC load controls.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pc_update  = 1'b0;
    pc_in      = pc_plus4;
    flush      = 1'b0;
    pend_valid = (state_q == ST_PEND);

    if (reset) begin
      pc_in      = RESET_PC;
      pend_valid = 1'b0;
      state_d    = ST_RUN;
      pend_d     = '0;
    end else if (bus.ExcReq) begin
      pc_in     = EXC_VECTOR;
      pc_update = 1'b1;
      flush     = 1'b1;
      pend_d    = '0;
      state_d   = ST_FLUSH;
    end else if (bus.EretReq) begin
      pc_in     = {bus.EPC[ADDR_W-1:2], 2'b00};
      pc_update = 1'b1;
      flush     = 1'b1;
      pend_d    = '0;
      state_d   = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.BrValid && !bus.Stall) begin
            pc_in     = bus.BrTarget;
            pc_update = 1'b1;
          end else if (bus.BrValid) begin
            pend_d  = bus.BrTarget;
            state_d = ST_PEND;
          end else begin
            pc_update = !bus.Stall;
          end
        end
        // First latched target wins; later redirects are ignored here.
        ST_PEND: begin
          if (!bus.Stall) begin
            pc_in     = pend_q;
            pc_update = 1'b1;
            pend_d    = '0;
            state_d   = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush     = 1'b1;
          pc_update = !bus.Stall;
          state_d   = ST_RUN;
        end
        default: begin
          pc_update = !bus.Stall;
          state_d   = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    pend_q  <= pend_d;
  end

  assign bus.PCUpdate  = pc_update;
  assign bus.PCIn      = pc_in;
  assign bus.Flush     = flush;
  assign bus.PendValid = pend_valid;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, redirect, stalled redirect, exception,
// ERET, PC wrap and reset-during-PEND, with hand-computed expectations.
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Stall    = 1'b0;
    bus.BrValid  = 1'b0;
    bus.BrTarget = 32'h0;
    bus.ExcReq   = 1'b0;
    bus.EretReq  = 1'b0;
    bus.EPC      = 32'h0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.PCOut = 32'h3000;
    idle_inputs();

    // Reset held for two edges.
    #1;
    chk("rst0_upd",  32'(bus.PCUpdate), 32'd0);
    chk("rst0_pcin", bus.PCIn, 32'h3000);
    chk("rst0_pend", 32'(bus.PendValid), 32'd0);
    chk("rst0_fl",   32'(bus.Flush), 32'd0);
    next_cycle();
    chk("rst1_upd",  32'(bus.PCUpdate), 32'd0);
    chk("rst1_pcin", bus.PCIn, 32'h3000);
    next_cycle();
    reset = 1'b0;
    #1;
    chk("post_rst_upd",  32'(bus.PCUpdate), 32'd1);
    chk("post_rst_pcin", bus.PCIn, 32'h3004);

    // Unstalled branch.
    bus.PCOut = 32'h3010; bus.BrValid = 1'b1; bus.BrTarget = 32'h3100;
    #1;
    chk("br_pcin", bus.PCIn, 32'h3100);
    chk("br_upd",  32'(bus.PCUpdate), 32'd1);
    chk("br_fl",   32'(bus.Flush), 32'd0);
    next_cycle();

    // Branch during stall: buffered, later redirects ignored.
    bus.PCOut = 32'h3100; bus.BrTarget = 32'h3200; bus.Stall = 1'b1;
    #1;
    chk("brst_upd", 32'(bus.PCUpdate), 32'd0);
    next_cycle();
    bus.BrTarget = 32'h3300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pend_valid", 32'(bus.PendValid), 32'd1);
      chk("pend_upd",   32'(bus.PCUpdate), 32'd0);
      next_cycle();
    end
    bus.Stall = 1'b0; bus.BrValid = 1'b0;
    #1;
    chk("pend_rel_pcin", bus.PCIn, 32'h3200);
    chk("pend_rel_upd",  32'(bus.PCUpdate), 32'd1);
    next_cycle();
    bus.PCOut = 32'h3200;
    #1;
    chk("pend_clr",   32'(bus.PendValid), 32'd0);
    chk("seq_pcin",   bus.PCIn, 32'h3204);

    // Exception beats stalled branch.
    bus.PCOut = 32'h3204; bus.ExcReq = 1'b1; bus.BrValid = 1'b1;
    bus.BrTarget = 32'h3400; bus.Stall = 1'b1;
    #1;
    chk("exc_pcin", bus.PCIn, 32'h4180);
    chk("exc_upd",  32'(bus.PCUpdate), 32'd1);
    chk("exc_fl",   32'(bus.Flush), 32'd1);
    next_cycle();
    bus.ExcReq = 1'b0; bus.Stall = 1'b0; bus.BrTarget = 32'h3500; bus.PCOut = 32'h4180;
    #1;
    chk("flush2_fl",   32'(bus.Flush), 32'd1);
    chk("flush2_pcin", bus.PCIn, 32'h4184);
    chk("flush2_upd",  32'(bus.PCUpdate), 32'd1);
    next_cycle();
    bus.BrValid = 1'b0; bus.PCOut = 32'h4184;
    #1;
    chk("run_fl",   32'(bus.Flush), 32'd0);
    chk("run_pcin", bus.PCIn, 32'h4188);
    next_cycle();

    // ERET while pending: pending discarded, EPC aligned.
    bus.PCOut = 32'h3010; bus.BrValid = 1'b1; bus.BrTarget = 32'h3600; bus.Stall = 1'b1;
    next_cycle();
    bus.BrValid = 1'b0; bus.EretReq = 1'b1; bus.EPC = 32'h3023;
    #1;
    chk("eret_pend_before", 32'(bus.PendValid), 32'd1);
    chk("eret_pcin", bus.PCIn, 32'h3020);
    chk("eret_upd",  32'(bus.PCUpdate), 32'd1);
    chk("eret_fl",   32'(bus.Flush), 32'd1);
    next_cycle();
    bus.EretReq = 1'b0; bus.Stall = 1'b0; bus.PCOut = 32'h3020;
    #1;
    chk("eret_pend_after", 32'(bus.PendValid), 32'd0);
    chk("eret_flush2",     32'(bus.Flush), 32'd1);
    chk("eret_flush2_pcin", bus.PCIn, 32'h3024);
    next_cycle();
    bus.PCOut = 32'h3024;
    #1;
    chk("eret_run_pcin", bus.PCIn, 32'h3028);
    chk("eret_run_fl",   32'(bus.Flush), 32'd0);

    // Exception outranks ERET.
    bus.ExcReq = 1'b1; bus.EretReq = 1'b1; bus.EPC = 32'h5000;
    #1;
    chk("exc_over_eret", bus.PCIn, 32'h4180);
    next_cycle();
    idle_inputs();
    next_cycle();

    // 32-bit wrap of sequential advance.
    bus.PCOut = 32'hFFFF_FFFC;
    #1;
    chk("wrap_pcin", bus.PCIn, 32'h0000_0000);
    chk("wrap_upd",  32'(bus.PCUpdate), 32'd1);

    // Reset while in PEND discards the buffered target.
    bus.PCOut = 32'h3000; bus.BrValid = 1'b1; bus.BrTarget = 32'h3700; bus.Stall = 1'b1;
    next_cycle();
    bus.BrValid = 1'b0;
    #1;
    chk("rstpend_pre", 32'(bus.PendValid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstpend_pend", 32'(bus.PendValid), 32'd0);
    chk("rstpend_pcin", bus.PCIn, 32'h3000);
    chk("rstpend_upd",  32'(bus.PCUpdate), 32'd0);
    next_cycle();
    reset = 1'b0; bus.Stall = 1'b0;
    #1;
    chk("rstpend_after_pend", 32'(bus.PendValid), 32'd0);
    chk("rstpend_after_pcin", bus.PCIn, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
